alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_pkg.sv | 44 ++++
 rtl/eightbit_alu.sv | 38 +++
 rtl/alu_arbiter.sv | 118 +++++++++++
 tb/tb_alu_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-port ALU arbiter: ALU opcodes, FSM encodings
// and the operand/result bundles passed between the arbiter and the ALU.
package alu_arbiter_pkg;

  localparam int unsigned DataW = 8;
  localparam int unsigned SelW  = 3;

  // eightbit_alu opcode table
  localparam logic [SelW-1:0] OpAdd  = 3'b000;
  localparam logic [SelW-1:0] OpNotB = 3'b001;
  localparam logic [SelW-1:0] OpAnd  = 3'b010;
  localparam logic [SelW-1:0] OpOr   = 3'b011;
  localparam logic [SelW-1:0] OpSra  = 3'b100;
  localparam logic [SelW-1:0] OpSla  = 3'b101;
  localparam logic [SelW-1:0] OpEq   = 3'b110;
  localparam logic [SelW-1:0] OpNe   = 3'b111;

  // Arbiter FSM encodings
  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StExec = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  typedef struct packed {
    logic             id;
    logic [SelW-1:0]  sel;
    logic [DataW-1:0] a;
    logic [DataW-1:0] b;
  } alu_op_t;

  typedef struct packed {
    logic             id;
    logic [DataW-1:0] f;
    logic             ovf;
    logic             zero;
  } alu_resp_t;

  // Signed overflow: operands agree in sign but the sum does not.
  function automatic logic add_ovf(input logic [DataW-1:0] a,
                                   input logic [DataW-1:0] b,
                                   input logic [DataW-1:0] sum);
    return (a[DataW-1] == b[DataW-1]) && (sum[DataW-1] != a[DataW-1]);
  endfunction

endpackage

// File: rtl/eightbit_alu.sv
// Combinational 8-bit signed ALU. Opcodes 110/111 only drive the zero/branch
// flag (equal / not equal) and leave the data result at zero.
module eightbit_alu
  import alu_arbiter_pkg::*;
(
  input  logic signed [DataW-1:0] a_i,
  input  logic signed [DataW-1:0] b_i,
  input  logic        [SelW-1:0]  sel_i,
  output logic signed [DataW-1:0] f_o,
  output logic                    ovf_o,
  output logic                    zero_o
);

  logic [DataW-1:0] sum;

  assign sum = a_i + b_i;

  always_comb begin
    f_o    = '0;
    ovf_o  = 1'b0;
    zero_o = 1'b0;
    unique case (sel_i)
      OpAdd: begin
        f_o   = sum;
        ovf_o = add_ovf(a_i, b_i, sum);
      end
      OpNotB:  f_o = ~b_i;
      OpAnd:   f_o = a_i & b_i;
      OpOr:    f_o = a_i | b_i;
      OpSra:   f_o = a_i >>> 1;
      OpSla:   f_o = a_i <<< 1;
      OpEq:    zero_o = (a_i == b_i);
      OpNe:    zero_o = (a_i != b_i);
      default: f_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of a single eightbit_alu: one operation in flight,
// IDLE -> EXEC -> DONE, round-robin or fixed-priority grant.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned RR_EN = 1
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [DataW-1:0] req0_a,
  input  logic [DataW-1:0] req0_b,
  input  logic [SelW-1:0]  req0_sel,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [DataW-1:0] req1_a,
  input  logic [DataW-1:0] req1_b,
  input  logic [SelW-1:0]  req1_sel,

  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [DataW-1:0] resp_f,
  output logic             resp_ovf,
  output logic             resp_zero,
  output logic             busy
);

  localparam logic RrEnable = (RR_EN != 0);

  logic [1:0] state_q, state_d;
  logic       prio_q, prio_d;
  alu_op_t    op_q, op_d;
  alu_resp_t  resp_q, resp_d;

  logic             idle;
  logic             gnt_valid;
  logic             gnt_id;
  logic [DataW-1:0] alu_f;
  logic             alu_ovf;
  logic             alu_zero;

  eightbit_alu u_alu (
    .a_i    (op_q.a),
    .b_i    (op_q.b),
    .sel_i  (op_q.sel),
    .f_o    (alu_f),
    .ovf_o  (alu_ovf),
    .zero_o (alu_zero)
  );

  assign idle = (state_q == StIdle);

  // With a lone requester gnt_id simply names it; contention uses the pointer.
  always_comb begin
    gnt_valid = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      gnt_id = RrEnable ? prio_q : 1'b0;
    end else begin
      gnt_id = req1_valid;
    end
  end

  assign req0_ready = idle & gnt_valid & ~gnt_id;
  assign req1_ready = idle & gnt_valid & gnt_id;

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    op_d    = op_q;
    resp_d  = resp_q;
    unique case (state_q)
      StIdle: begin
        if (gnt_valid) begin
          op_d = gnt_id ? alu_op_t'{id: 1'b1, sel: req1_sel, a: req1_a, b: req1_b}
                        : alu_op_t'{id: 1'b0, sel: req0_sel, a: req0_a, b: req0_b};
          state_d = StExec;
        end
      end
      StExec: begin
        resp_d  = alu_resp_t'{id: op_q.id, f: alu_f, ovf: alu_ovf, zero: alu_zero};
        state_d = StDone;
      end
      StDone: begin
        if (resp_ready) begin
          state_d = StIdle;
          prio_d  = RrEnable ? ~resp_q.id : 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      prio_q  <= 1'b0;
      op_q    <= '0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      op_q    <= op_d;
      resp_q  <= resp_d;
    end
  end

  assign resp_valid = (state_q == StDone);
  assign busy       = ~idle;
  assign resp_id    = resp_q.id;
  assign resp_f     = resp_q.f;
  assign resp_ovf   = resp_q.ovf;
  assign resp_zero  = resp_q.zero;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a round-robin and a fixed-priority instance share the
// same stimulus; directed scenarios plus a randomized run against a
// transaction-level reference model.
module tb_alu_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       req0_valid, req1_valid, resp_ready;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0] req0_sel, req1_sel;

  logic       rr_r0, rr_r1, rr_rv, rr_id, rr_ovf, rr_zero, rr_busy;
  logic [7:0] rr_f;
  logic       fp_r0, fp_r1, fp_rv, fp_id, fp_ovf, fp_zero, fp_busy;
  logic [7:0] fp_f;

  int n_run  = 0;
  int n_fail = 0;

  alu_arbiter #(.RR_EN(1)) u_rr (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(rr_r0), .req0_a(req0_a), .req0_b(req0_b),
    .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(rr_r1), .req1_a(req1_a), .req1_b(req1_b),
    .req1_sel(req1_sel),
    .resp_valid(rr_rv), .resp_ready(resp_ready), .resp_id(rr_id), .resp_f(rr_f),
    .resp_ovf(rr_ovf), .resp_zero(rr_zero), .busy(rr_busy)
  );

  alu_arbiter #(.RR_EN(0)) u_fp (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(fp_r0), .req0_a(req0_a), .req0_b(req0_b),
    .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(fp_r1), .req1_a(req1_a), .req1_b(req1_b),
    .req1_sel(req1_sel),
    .resp_valid(fp_rv), .resp_ready(resp_ready), .resp_id(fp_id), .resp_f(fp_f),
    .resp_ovf(fp_ovf), .resp_zero(fp_zero), .busy(fp_busy)
  );

  // Index 0 = round-robin instance, 1 = fixed-priority instance.
  logic [1:0]      r0_v, r1_v, rv_v, busy_v, id_v, ovf_v, zero_v;
  logic [1:0][7:0] f_v;
  assign r0_v   = {fp_r0, rr_r0};
  assign r1_v   = {fp_r1, rr_r1};
  assign rv_v   = {fp_rv, rr_rv};
  assign busy_v = {fp_busy, rr_busy};
  assign id_v   = {fp_id, rr_id};
  assign ovf_v  = {fp_ovf, rr_ovf};
  assign zero_v = {fp_zero, rr_zero};
  assign f_v    = {fp_f, rr_f};

  // Reference ALU from the opcode table, in plain integer arithmetic: {f, ovf, zero}.
  function automatic logic [9:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                         input logic [2:0] sel);
    int ai = $signed(a);
    int bi = $signed(b);
    int s  = 0;
    logic [7:0] f = 8'h00;
    logic ovf = 1'b0;
    logic zero = 1'b0;
    case (sel)
      3'd0: begin s = ai + bi; f = s[7:0]; ovf = (s > 127) || (s < -128); end
      3'd1: f = ~b;
      3'd2: f = a & b;
      3'd3: f = a | b;
      3'd4: begin s = ai >>> 1; f = s[7:0]; end
      3'd5: begin s = ai * 2;   f = s[7:0]; end
      3'd6: zero = (a == b);
      default: zero = (a != b);
    endcase
    return {f, ovf, zero};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req0_valid = 0; req1_valid = 0; resp_ready = 0;
    req0_a = 0; req0_b = 0; req0_sel = 0;
    req1_a = 0; req1_b = 0; req1_sel = 0;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    for (int m = 0; m < 2; m++) begin
      n_run++; if (rv_v[m] !== 1'b0) begin n_fail++;
        $display("FAIL reset_resp_valid[%0d] got %b want 0", m, rv_v[m]); end
      n_run++; if (busy_v[m] !== 1'b0) begin n_fail++;
        $display("FAIL reset_busy[%0d] got %b want 0", m, busy_v[m]); end
      n_run++; if (f_v[m] !== 8'h00) begin n_fail++;
        $display("FAIL reset_resp_f[%0d] got %h want 00", m, f_v[m]); end
      n_run++; if ({id_v[m], ovf_v[m], zero_v[m]} !== 3'b000) begin n_fail++;
        $display("FAIL reset_flags[%0d] got %b want 000", m, {id_v[m], ovf_v[m], zero_v[m]});
      end
      n_run++; if ({r0_v[m], r1_v[m]} !== 2'b00) begin n_fail++;
        $display("FAIL reset_ready[%0d] got %b want 00", m, {r0_v[m], r1_v[m]}); end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    req0_valid = 1; req0_a = 8'h7F; req0_b = 8'h01; req0_sel = 3'b000;
    #1;
    n_run++; if ({rr_r0, rr_r1, fp_r0, fp_r1} !== 4'b1010) begin n_fail++;
      $display("FAIL ovf_ready got %b want 1010", {rr_r0, rr_r1, fp_r0, fp_r1}); end
    tick();
    req0_valid = 0;
    n_run++; if ({rr_busy, rr_rv} !== 2'b10) begin n_fail++;
      $display("FAIL ovf_exec busy/valid got %b want 10", {rr_busy, rr_rv}); end
    tick();
    n_run++; if ({rr_rv, rr_f, rr_ovf, rr_id, rr_zero} !== {1'b1, 8'h80, 3'b100}) begin
      n_fail++;
      $display("FAIL ovf_resp got v=%b f=%h ovf=%b id=%b z=%b want v=1 f=80 ovf=1 id=0 z=0",
               rr_rv, rr_f, rr_ovf, rr_id, rr_zero);
    end
    n_run++; if ({fp_rv, fp_f, fp_ovf} !== {1'b1, 8'h80, 1'b1}) begin n_fail++;
      $display("FAIL ovf_resp_fp got v=%b f=%h ovf=%b want 1 80 1", fp_rv, fp_f, fp_ovf); end
    resp_ready = 1;
    tick();
    resp_ready = 0;
    n_run++; if ({rr_rv, rr_busy} !== 2'b00) begin n_fail++;
      $display("FAIL ovf_release got %b want 00", {rr_rv, rr_busy}); end
  endtask

  task automatic test_arbitration();
    logic [7:0] rr_fq[$], fp_fq[$];
    logic       rr_iq[$], fp_iq[$];
    int         rr_cq[$];
    int         fp_r1_seen = 0;
    do_reset();
    req0_valid = 1; req0_a = 8'hF0; req0_b = 8'h3C; req0_sel = 3'b010;
    req1_valid = 1; req1_a = 8'h0F; req1_b = 8'h30; req1_sel = 3'b011;
    resp_ready = 1;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (fp_r1) fp_r1_seen++;
      @(posedge clk);
      #1;
      if (rr_rv) begin rr_fq.push_back(rr_f); rr_iq.push_back(rr_id); rr_cq.push_back(i); end
      if (fp_rv) begin fp_fq.push_back(fp_f); fp_iq.push_back(fp_id); end
    end
    req0_valid = 0; req1_valid = 0; resp_ready = 0;
    n_run++; if (rr_fq.size() < 3) begin n_fail++;
      $display("FAIL rr_count got %0d want >=3", rr_fq.size()); end
    n_run++; if (fp_fq.size() < 3) begin n_fail++;
      $display("FAIL fp_count got %0d want >=3", fp_fq.size()); end
    if (rr_fq.size() >= 3) begin
      n_run++; if ({rr_iq[0], rr_iq[1], rr_iq[2]} !== 3'b010) begin n_fail++;
        $display("FAIL rr_ids got %b%b%b want 010", rr_iq[0], rr_iq[1], rr_iq[2]); end
      n_run++; if ({rr_fq[0], rr_fq[1], rr_fq[2]} !== {8'h30, 8'h3F, 8'h30}) begin n_fail++;
        $display("FAIL rr_f got %h %h %h want 30 3f 30", rr_fq[0], rr_fq[1], rr_fq[2]); end
      n_run++; if (rr_cq[1] - rr_cq[0] != 3) begin n_fail++;
        $display("FAIL rr_interval got %0d want 3", rr_cq[1] - rr_cq[0]); end
    end
    if (fp_fq.size() >= 3) begin
      n_run++; if ({fp_iq[0], fp_iq[1], fp_iq[2]} !== 3'b000) begin n_fail++;
        $display("FAIL fp_ids got %b%b%b want 000", fp_iq[0], fp_iq[1], fp_iq[2]); end
      n_run++; if ({fp_fq[0], fp_fq[1], fp_fq[2]} !== {3{8'h30}}) begin n_fail++;
        $display("FAIL fp_f got %h %h %h want 30 30 30", fp_fq[0], fp_fq[1], fp_fq[2]); end
    end
    n_run++; if (fp_r1_seen != 0) begin n_fail++;
      $display("FAIL fp_port1_granted got %0d want 0", fp_r1_seen); end
  endtask

  task automatic test_hold();
    int waited = 0;
    do_reset();
    req0_valid = 1; req0_a = 8'h55; req0_b = 8'h55; req0_sel = 3'b110;
    req1_valid = 1; req1_a = 8'h12; req1_b = 8'h34; req1_sel = 3'b000;
    while (!rr_rv && waited < 6) begin tick(); waited++; end
    n_run++; if (rr_rv !== 1'b1) begin n_fail++;
      $display("FAIL hold_wait got resp_valid=%b want 1", rr_rv); end
    for (int i = 0; i < 5; i++) begin
      n_run++;
      if ({rr_rv, rr_f, rr_zero, rr_ovf, rr_id, rr_r0, rr_r1, rr_busy}
          !== {1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1}) begin
        n_fail++;
        $display("FAIL hold_cycle%0d got v=%b f=%h z=%b o=%b id=%b rdy=%b%b busy=%b want 1 00 1 0 0 00 1",
                 i, rr_rv, rr_f, rr_zero, rr_ovf, rr_id, rr_r0, rr_r1, rr_busy);
      end
      n_run++; if ({fp_rv, fp_f, fp_zero} !== {1'b1, 8'h00, 1'b1}) begin n_fail++;
        $display("FAIL hold_fp%0d got %b %h %b want 1 00 1", i, fp_rv, fp_f, fp_zero); end
      tick();
    end
    req0_valid = 0; req1_valid = 0; resp_ready = 1;
    tick();
    resp_ready = 0;
    n_run++; if ({rr_rv, rr_busy} !== 2'b00) begin n_fail++;
      $display("FAIL hold_release got %b want 00", {rr_rv, rr_busy}); end
  endtask

  task automatic test_reset_exec();
    do_reset();
    // Serve port 0 once so the round-robin pointer moves to port 1.
    req0_valid = 1; req0_a = 8'h0F; req0_b = 8'h30; req0_sel = 3'b011;
    tick();
    req0_valid = 0;
    tick();
    resp_ready = 1;
    tick();
    resp_ready = 0;
    req1_valid = 1; req1_a = 8'h01; req1_b = 8'h01; req1_sel = 3'b000;
    tick();
    req1_valid = 0;
    #2;
    rst = 1;
    #1;
    n_run++; if ({rr_rv, rr_busy, rr_f, rr_ovf, rr_zero, rr_id} !== 13'd0) begin n_fail++;
      $display("FAIL rst_exec_async got v=%b b=%b f=%h o=%b z=%b id=%b want all 0",
               rr_rv, rr_busy, rr_f, rr_ovf, rr_zero, rr_id);
    end
    n_run++; if ({fp_busy, fp_f} !== 9'd0) begin n_fail++;
      $display("FAIL rst_exec_async_fp got %b %h want 0 00", fp_busy, fp_f); end
    @(posedge clk);
    #1;
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_run++; if ({rr_rv, fp_rv} !== 2'b00) begin n_fail++;
        $display("FAIL rst_exec_ghost%0d got %b want 00", i, {rr_rv, fp_rv}); end
    end
    req0_valid = 1; req0_a = 8'h21; req0_b = 8'h10; req0_sel = 3'b000;
    req1_valid = 1; req1_a = 8'h01; req1_b = 8'h01; req1_sel = 3'b000;
    #1;
    n_run++; if ({rr_r0, rr_r1} !== 2'b10) begin n_fail++;
      $display("FAIL rst_exec_prio got %b want 10", {rr_r0, rr_r1}); end
    tick();
    req0_valid = 0; req1_valid = 0;
    tick();
    n_run++; if ({rr_rv, rr_id, rr_f} !== {1'b1, 1'b0, 8'h31}) begin n_fail++;
      $display("FAIL rst_exec_next got v=%b id=%b f=%h want 1 0 31", rr_rv, rr_id, rr_f); end
    resp_ready = 1;
    tick();
    resp_ready = 0;
  endtask

  task automatic test_random();
    bit         has_txn [2];
    int         acc [2];
    bit         prio [2];
    logic [9:0] exp_res [2];
    bit         exp_id [2];
    bit         do_acc [2], do_rel [2];
    logic [9:0] nxt_res [2];
    bit         nxt_id [2];
    int         cyc = 0;
    do_reset();
    for (int m = 0; m < 2; m++) begin has_txn[m] = 0; prio[m] = 0; acc[m] = 0; end
    for (int c = 0; c < 400; c++) begin
      req0_valid = 1'($urandom_range(0, 1));
      req1_valid = 1'($urandom_range(0, 1));
      req0_a = 8'($urandom); req0_b = 8'($urandom); req0_sel = 3'($urandom);
      req1_a = 8'($urandom); req1_b = 8'($urandom); req1_sel = 3'($urandom);
      if ($urandom_range(0, 5) == 0) req1_b = req1_a;
      resp_ready = ($urandom_range(0, 3) != 0);
      #1;
      for (int m = 0; m < 2; m++) begin
        bit e_idle, e_valid, e_win, e_r0, e_r1;
        e_idle  = !has_txn[m];
        e_valid = has_txn[m] && (cyc >= acc[m] + 1);
        if (req0_valid && req1_valid) e_win = (m == 0) ? prio[m] : 1'b0;
        else e_win = req1_valid;
        e_r0 = e_idle && (req0_valid || req1_valid) && !e_win;
        e_r1 = e_idle && (req0_valid || req1_valid) && e_win;
        n_run++;
        if ({r0_v[m], r1_v[m], rv_v[m], busy_v[m]} !== {e_r0, e_r1, e_valid, !e_idle}) begin
          n_fail++;
          $display("FAIL rand_ctrl[%0d] cyc%0d got rdy=%b%b v=%b busy=%b want %b%b %b %b",
                   m, cyc, r0_v[m], r1_v[m], rv_v[m], busy_v[m], e_r0, e_r1, e_valid, !e_idle);
        end
        if (e_valid) begin
          n_run++;
          if ({id_v[m], f_v[m], ovf_v[m], zero_v[m]} !== {exp_id[m], exp_res[m]}) begin
            n_fail++;
            $display("FAIL rand_resp[%0d] cyc%0d got id=%b f=%h o=%b z=%b want id=%b f=%h o=%b z=%b",
                     m, cyc, id_v[m], f_v[m], ovf_v[m], zero_v[m], exp_id[m],
                     exp_res[m][9:2], exp_res[m][1], exp_res[m][0]);
          end
        end
        do_acc[m] = e_r0 || e_r1;
        do_rel[m] = e_valid && resp_ready;
        nxt_id[m] = e_win;
        nxt_res[m] = e_win ? ref_alu(req1_a, req1_b, req1_sel) : ref_alu(req0_a, req0_b, req0_sel);
      end
      @(posedge clk);
      cyc++;
      for (int m = 0; m < 2; m++) begin
        if (do_acc[m]) begin
          has_txn[m] = 1; acc[m] = cyc; exp_id[m] = nxt_id[m]; exp_res[m] = nxt_res[m];
        end else if (do_rel[m]) begin
          has_txn[m] = 0;
          if (m == 0) prio[m] = !exp_id[m];
        end
      end
      #1;
    end
    req0_valid = 0; req1_valid = 0; resp_ready = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_overflow();
    test_arbitration();
    test_hold();
    test_reset_exec();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
